// File: rtl/ss_mux_driver_if.sv
// Display-side bundle for ss_mux_driver: digit codes, per-digit controls, and the
// anode/segment/frame outputs. The driver uses the slave modport; its source uses master.
interface ss_mux_driver_if #(
    parameter int NUM_DIGITS = 8,
    parameter int PWM_BITS   = 4
);
    logic [6*NUM_DIGITS-1:0] Digits;
    logic [NUM_DIGITS-1:0]   DP;
    logic [NUM_DIGITS-1:0]   DigitEnable;
    logic [PWM_BITS-1:0]     Brightness;
    logic [NUM_DIGITS-1:0]   SegmentDrivers;
    logic [7:0]              SevenSegment;
    logic                    FrameStrobe;

    modport master (
        output Digits, DP, DigitEnable, Brightness,
        input  SegmentDrivers, SevenSegment, FrameStrobe
    );

    modport slave (
        input  Digits, DP, DigitEnable, Brightness,
        output SegmentDrivers, SevenSegment, FrameStrobe
    );
endinterface

// File: rtl/ss_mux_driver.sv
// Multiplexed seven-segment driver: one digit per SCAN_DIV-cycle slot, with blanking,
// PWM brightness, per-digit enable and slot-start input latching; outputs registered (1 cycle).
module ss_mux_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 131072,
    parameter int BLANK_CYCLES = 64,
    parameter int PWM_BITS     = 4,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    ss_mux_driver_if.slave    bus
);
    localparam int   PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int   IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic POL   = (ACTIVE_LOW != 0);

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]      r_prescaler;
    logic [IDX_W-1:0]      r_idx;
    logic [PWM_BITS-1:0]   r_pwm_cnt;
    logic [PWM_BITS-1:0]   r_bright;
    logic [5:0]            r_sh_code;
    logic                  r_sh_dp;
    logic                  r_sh_en;
    logic [NUM_DIGITS-1:0] r_anodes;
    logic [7:0]            r_segments;
    logic                  r_frame;

    logic                  w_slot_start;
    logic                  w_slot_end;
    logic                  w_last_digit;
    logic                  w_pwm_on;
    logic                  w_lit;
    logic [5:0]            w_code_sel;
    logic [6:0]            w_glyph;
    logic [NUM_DIGITS-1:0] w_anodes;
    logic [7:0]            w_segments;

    assign w_slot_start = (r_prescaler == '0);
    assign w_slot_end   = (r_prescaler == PRE_LAST);
    assign w_last_digit = (r_idx == IDX_LAST);
    assign w_code_sel   = bus.Digits[6*r_idx +: 6];

    // All-ones brightness must be continuously on, which the compare alone cannot give.
    assign w_pwm_on = (&r_bright) || (r_pwm_cnt < r_bright);

    // Shadows are refreshed at prescaler 0, always inside the blanking window, so the
    // lit window only ever sees values belonging to the current slot.
    assign w_lit = (r_prescaler >= PRE_BLANK) && r_sh_en && w_pwm_on;

    always_comb begin
        w_glyph = 7'h00;
        case (r_sh_code)
            6'd0:  w_glyph = 7'h3F;
            6'd1:  w_glyph = 7'h06;
            6'd2:  w_glyph = 7'h5B;
            6'd3:  w_glyph = 7'h4F;
            6'd4:  w_glyph = 7'h66;
            6'd5:  w_glyph = 7'h6D;
            6'd6:  w_glyph = 7'h7D;
            6'd7:  w_glyph = 7'h07;
            6'd8:  w_glyph = 7'h7F;
            6'd9:  w_glyph = 7'h6F;
            6'd10: w_glyph = 7'h77;
            6'd11: w_glyph = 7'h7C;
            6'd12: w_glyph = 7'h39;
            6'd13: w_glyph = 7'h5E;
            6'd14: w_glyph = 7'h79;
            6'd15: w_glyph = 7'h71;
            6'd16: w_glyph = 7'h40;
            default: w_glyph = 7'h00;
        endcase
    end

    always_comb begin
        w_anodes   = '0;
        w_segments = 8'h00;
        if (w_lit) begin
            w_anodes   = NUM_DIGITS'(1) << r_idx;
            w_segments = {r_sh_dp, w_glyph};
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_prescaler <= '0;
            r_idx       <= '0;
            r_pwm_cnt   <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            if (w_slot_end) begin
                r_prescaler <= '0;
                r_idx       <= w_last_digit ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_prescaler <= r_prescaler + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_sh_code <= '0;
            r_sh_dp   <= 1'b0;
            r_sh_en   <= 1'b0;
            r_bright  <= '0;
        end else if (w_slot_start) begin
            r_sh_code <= w_code_sel;
            r_sh_dp   <= bus.DP[r_idx];
            r_sh_en   <= bus.DigitEnable[r_idx];
            if (r_idx == '0) begin
                r_bright <= bus.Brightness;
            end
        end
    end

    // Output polarity is applied here so everything upstream is active-high.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_anodes   <= {NUM_DIGITS{POL}};
            r_segments <= {8{POL}};
            r_frame    <= 1'b0;
        end else begin
            r_anodes   <= w_anodes ^ {NUM_DIGITS{POL}};
            r_segments <= w_segments ^ {8{POL}};
            r_frame    <= w_slot_end && w_last_digit;
        end
    end

    assign bus.SegmentDrivers = r_anodes;
    assign bus.SevenSegment   = r_segments;
    assign bus.FrameStrobe    = r_frame;

endmodule

// File: tb/tb_ss_mux_driver.sv
// Directed bench for ss_mux_driver with 4 digits, 16-cycle slots, 2 blank cycles, 2-bit PWM.
module tb_ss_mux_driver;
    logic Clk;
    logic Reset;

    ss_mux_driver_if #(.NUM_DIGITS(4), .PWM_BITS(2)) bus ();

    ss_mux_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(16), .BLANK_CYCLES(2), .PWM_BITS(2), .ACTIVE_LOW(1)
    ) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [23:0] digits;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [1:0]  bright;
        int          n;
        logic [3:0]  an;
        logic [7:0]  seg;
        logic        fs;
    } vec_t;

    localparam logic [23:0] D0 = {6'd4, 6'd3, 6'd2, 6'd1};

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(string nm, logic [23:0] d, logic [3:0] dp, logic [3:0] en,
                                logic [1:0] b, int n, logic [3:0] an, logic [7:0] seg,
                                logic fs);
        vec_t v;
        v.name = nm; v.digits = d; v.dp = dp; v.en = en; v.bright = b;
        v.n = n; v.an = an; v.seg = seg; v.fs = fs;
        return v;
    endfunction

    task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_inputs(logic [23:0] d, logic [3:0] dp, logic [3:0] en, logic [1:0] b);
        bus.Digits = d; bus.DP = dp; bus.DigitEnable = en; bus.Brightness = b;
    endtask

    // After this returns, the next rising edge is the first one with Reset high (n = 0).
    task automatic do_reset();
        Reset = 1'b0;
        repeat (3) step();
        Reset = 1'b1;
    endtask

    task automatic check_all(string nm, logic [3:0] an, logic [7:0] seg, logic fs);
        check({nm, ".an"},  {4'h0, bus.SegmentDrivers}, {4'h0, an});
        check({nm, ".seg"}, bus.SevenSegment, seg);
        check({nm, ".fs"},  {7'h0, bus.FrameStrobe}, {7'h0, fs});
    endtask

    initial begin
        int lows[4];
        int strobes;
        int first_fs;
        int second_fs;
        int bad;

        Reset = 1'b0;
        set_inputs(D0, 4'h0, 4'hF, 2'd3);

        // Reset held: outputs dark every cycle.
        for (int i = 0; i < 5; i++) begin
            step();
            check_all($sformatf("reset_hold%0d", i), 4'hF, 8'hFF, 1'b0);
        end

        vecs.push_back(mk("blank0",     D0, 4'h0, 4'hF, 2'd3, 0,  4'hF, 8'hFF, 1'b0));
        vecs.push_back(mk("blank1",     D0, 4'h0, 4'hF, 2'd3, 1,  4'hF, 8'hFF, 1'b0));
        vecs.push_back(mk("d0_on",      D0, 4'h0, 4'hF, 2'd3, 2,  4'hE, 8'hF9, 1'b0));
        vecs.push_back(mk("d0_end",     D0, 4'h0, 4'hF, 2'd3, 15, 4'hE, 8'hF9, 1'b0));
        vecs.push_back(mk("d1_blank",   D0, 4'h0, 4'hF, 2'd3, 16, 4'hF, 8'hFF, 1'b0));
        vecs.push_back(mk("d1_on",      D0, 4'h0, 4'hF, 2'd3, 18, 4'hD, 8'hA4, 1'b0));
        vecs.push_back(mk("d2_on",      D0, 4'h0, 4'hF, 2'd3, 34, 4'hB, 8'hB0, 1'b0));
        vecs.push_back(mk("d3_on",      D0, 4'h0, 4'hF, 2'd3, 50, 4'h7, 8'h99, 1'b0));
        vecs.push_back(mk("frame_end",  D0, 4'h0, 4'hF, 2'd3, 63, 4'h7, 8'h99, 1'b1));
        vecs.push_back(mk("frame_wrap", D0, 4'h0, 4'hF, 2'd3, 64, 4'hF, 8'hFF, 1'b0));
        vecs.push_back(mk("frame2_d0",  D0, 4'h0, 4'hF, 2'd3, 66, 4'hE, 8'hF9, 1'b0));
        vecs.push_back(mk("b1_pwm0",    D0, 4'h0, 4'hF, 2'd1, 4,  4'hE, 8'hF9, 1'b0));
        vecs.push_back(mk("b1_pwm1",    D0, 4'h0, 4'hF, 2'd1, 5,  4'hF, 8'hFF, 1'b0));
        vecs.push_back(mk("b1_pwm3",    D0, 4'h0, 4'hF, 2'd1, 7,  4'hF, 8'hFF, 1'b0));
        vecs.push_back(mk("b1_d1",      D0, 4'h0, 4'hF, 2'd1, 20, 4'hD, 8'hA4, 1'b0));
        vecs.push_back(mk("b0_d0",      D0, 4'h0, 4'hF, 2'd0, 4,  4'hF, 8'hFF, 1'b0));
        vecs.push_back(mk("b0_d3",      D0, 4'h0, 4'hF, 2'd0, 52, 4'hF, 8'hFF, 1'b0));
        vecs.push_back(mk("en_d2_off",  D0, 4'h0, 4'hB, 2'd3, 34, 4'hF, 8'hFF, 1'b0));
        vecs.push_back(mk("en_d3_on",   D0, 4'h0, 4'hB, 2'd3, 50, 4'h7, 8'h99, 1'b0));
        vecs.push_back(mk("dp_d0",      D0, 4'h1, 4'hF, 2'd3, 2,  4'hE, 8'h79, 1'b0));
        vecs.push_back(mk("dp_d1_off",  D0, 4'h1, 4'hF, 2'd3, 18, 4'hD, 8'hA4, 1'b0));
        vecs.push_back(mk("code16", {6'd4, 6'd3, 6'd2, 6'd16}, 4'h0, 4'hF, 2'd3, 2, 4'hE, 8'hBF, 1'b0));
        vecs.push_back(mk("code40", {6'd4, 6'd3, 6'd2, 6'd40}, 4'h0, 4'hF, 2'd3, 2, 4'hE, 8'hFF, 1'b0));
        vecs.push_back(mk("code40dp", {6'd4, 6'd3, 6'd2, 6'd40}, 4'h1, 4'hF, 2'd3, 2, 4'hE, 8'h7F, 1'b0));
        vecs.push_back(mk("code0",  {6'd4, 6'd3, 6'd2, 6'd0},  4'h0, 4'hF, 2'd3, 2, 4'hE, 8'hC0, 1'b0));
        vecs.push_back(mk("codeA",  {6'd4, 6'd3, 6'd2, 6'd10}, 4'h0, 4'hF, 2'd3, 2, 4'hE, 8'h88, 1'b0));
        vecs.push_back(mk("codeF",  {6'd4, 6'd3, 6'd2, 6'd15}, 4'h0, 4'hF, 2'd3, 2, 4'hE, 8'h8E, 1'b0));
        vecs.push_back(mk("code8",  {6'd4, 6'd3, 6'd2, 6'd8},  4'h0, 4'hF, 2'd3, 2, 4'hE, 8'h80, 1'b0));

        foreach (vecs[i]) begin
            set_inputs(vecs[i].digits, vecs[i].dp, vecs[i].en, vecs[i].bright);
            do_reset();
            repeat (vecs[i].n + 1) step();
            check_all(vecs[i].name, vecs[i].an, vecs[i].seg, vecs[i].fs);
        end

        // Two full frames at full brightness: 14 lit cycles per digit per frame, one-hot
        // anodes, strobes 64 cycles apart.
        set_inputs(D0, 4'h0, 4'hF, 2'd3);
        do_reset();
        lows = '{0, 0, 0, 0};
        strobes = 0; first_fs = -1; second_fs = -1; bad = 0;
        for (int n = 0; n < 128; n++) begin
            step();
            for (int d = 0; d < 4; d++) if (!bus.SegmentDrivers[d]) lows[d]++;
            if ($countones(~bus.SegmentDrivers) > 1) bad++;
            if (bus.FrameStrobe) begin
                strobes++;
                if (first_fs < 0) first_fs = n; else second_fs = n;
            end
        end
        for (int d = 0; d < 4; d++) check($sformatf("scan_low_d%0d", d), 8'(lows[d]), 8'd28);
        check("scan_onehot_violations", 8'(bad), 8'd0);
        check("scan_strobe_count", 8'(strobes), 8'd2);
        check("scan_strobe_first", 8'(first_fs), 8'd63);
        check("scan_strobe_period", 8'(second_fs - first_fs), 8'd64);

        // Brightness 0: no anode for a whole frame.
        set_inputs(D0, 4'h0, 4'hF, 2'd0);
        do_reset();
        bad = 0;
        for (int n = 0; n < 64; n++) begin
            step();
            if (bus.SegmentDrivers !== 4'hF || bus.SevenSegment !== 8'hFF) bad++;
        end
        check("b0_frame_lit_cycles", 8'(bad), 8'd0);

        // Digit code changed mid-slot 0 only shows from slot 0 of the next frame.
        set_inputs(D0, 4'h0, 4'hF, 2'd3);
        do_reset();
        repeat (6) step();
        check_all("midchg_n5", 4'hE, 8'hF9, 1'b0);
        bus.Digits = {6'd4, 6'd3, 6'd2, 6'd8};
        repeat (5) step();
        check_all("midchg_n10", 4'hE, 8'hF9, 1'b0);
        repeat (56) step();
        check_all("midchg_n66", 4'hE, 8'h80, 1'b0);

        // Brightness is only sampled at frame start.
        set_inputs(D0, 4'h0, 4'hF, 2'd3);
        do_reset();
        repeat (11) step();
        bus.Brightness = 2'd0;
        repeat (10) step();
        check_all("bchg_n20", 4'hD, 8'hA4, 1'b0);
        repeat (46) step();
        check_all("bchg_n66", 4'hF, 8'hFF, 1'b0);

        // Reset at prescaler 7 of slot 2, then restart at digit 0 with blanking.
        set_inputs(D0, 4'h0, 4'hF, 2'd3);
        do_reset();
        repeat (39) step();
        check_all("midrst_before", 4'hB, 8'hB0, 1'b0);
        Reset = 1'b0;
        step();
        check_all("midrst_off", 4'hF, 8'hFF, 1'b0);
        Reset = 1'b1;
        step();
        check_all("midrst_n0", 4'hF, 8'hFF, 1'b0);
        step();
        check_all("midrst_n1", 4'hF, 8'hFF, 1'b0);
        step();
        check_all("midrst_n2", 4'hE, 8'hF9, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
